dmem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported, byte-addressable data memory (1 KB, combinational read, write on rising clock edge) between the core load/store unit (port 0) and the test/loader DMA (port 1). It accepts word requests on a valid/ready handshake and grants one request per cycle, round-robin. It drives the memory's `mem_read`, `mem_write`, `addr` and `wd` inputs, and returns a registered response carrying read data or an error flag. Requests that are misaligned or out of range are rejected here and never reach the memory.

---
 rtl/dmem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-ported, byte-addressable data memory between two word
// requesters: port 0 (core load/store unit) and port 1 (test/loader DMA).
// One request is granted per cycle, round-robin on ties. Misaligned or
// out-of-range requests are accepted but never reach the memory; they come
// back with an error flag instead. Every accepted request produces exactly one
// registered response one cycle later.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pN_req_valid/ready         request handshake (ready = granted this cycle)
//   pN_req_we                  1 = write, 0 = read
//   pN_req_addr                byte address (must be word aligned)
//   pN_req_wdata               write data, little-endian
//   pN_rsp_valid/ready         one-entry response slot handshake
//   pN_rsp_rdata               read data (0 for writes and rejected requests)
//   pN_rsp_err                 request was rejected
//   mem_read, mem_write        memory strobes (only for legal granted requests)
//   mem_addr, mem_wd           memory address / write data (0 when idle)
//   mem_rd                     combinational memory read data
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int unsigned ADDR_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic        p0_req_we,
   input  logic [31:0] p0_req_addr,
   input  logic [31:0] p0_req_wdata,
   output logic        p0_rsp_valid,
   input  logic        p0_rsp_ready,
   output logic [31:0] p0_rsp_rdata,
   output logic        p0_rsp_err,

   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic        p1_req_we,
   input  logic [31:0] p1_req_addr,
   input  logic [31:0] p1_req_wdata,
   output logic        p1_rsp_valid,
   input  logic        p1_rsp_ready,
   output logic [31:0] p1_rsp_rdata,
   output logic        p1_rsp_err,

   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   // Highest legal word address, kept at full 32-bit width so that large
   // addresses can never alias into the memory range.
   localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

   function automatic logic addr_legal(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
   endfunction

   // Only legal reads return memory data; writes and rejects return zero.
   function automatic logic [31:0] rsp_data(input logic        legal,
                                            input logic        we,
                                            input logic [31:0] rd);
      return (legal && !we) ? rd : 32'd0;
   endfunction

   // last_grant: 0 = port 0 won most recently, 1 = port 1.
   logic        last_grant;

   logic        vld0_p1;
   logic [31:0] rdata0_p1;
   logic        err0_p1;
   logic        vld1_p1;
   logic [31:0] rdata1_p1;
   logic        err1_p1;

   logic        elig0_p0;
   logic        elig1_p0;
   logic        gnt0_p0;
   logic        gnt1_p0;
   logic        gnt_p0;
   logic        sel_we_p0;
   logic [31:0] sel_addr_p0;
   logic [31:0] sel_wdata_p0;
   logic        legal_p0;
   logic [31:0] rsp_rdata_p0;
   logic        rsp_err_p0;

   // ---- stage p0: eligibility, arbitration, legality, memory access ----
   always_comb begin
      // A port may only be granted if its response slot is free or is being
      // drained in this same cycle.
      elig0_p0 = p0_req_valid && (!vld0_p1 || p0_rsp_ready);
      elig1_p0 = p1_req_valid && (!vld1_p1 || p1_rsp_ready);

      // On a tie the port that did not win last time is granted.
      gnt0_p0 = elig0_p0 && (!elig1_p0 ||  last_grant);
      gnt1_p0 = elig1_p0 && (!elig0_p0 || !last_grant);
      gnt_p0  = gnt0_p0 || gnt1_p0;

      sel_we_p0    = gnt1_p0 ? p1_req_we    : p0_req_we;
      sel_addr_p0  = gnt1_p0 ? p1_req_addr  : p0_req_addr;
      sel_wdata_p0 = gnt1_p0 ? p1_req_wdata : p0_req_wdata;

      legal_p0 = gnt_p0 && addr_legal(sel_addr_p0);

      // Rejected requests keep the memory bus fully idle.
      mem_read  = legal_p0 && !sel_we_p0;
      mem_write = legal_p0 &&  sel_we_p0;
      mem_addr  = legal_p0 ? sel_addr_p0 : 32'd0;
      mem_wd    = (legal_p0 && sel_we_p0) ? sel_wdata_p0 : 32'd0;

      rsp_rdata_p0 = rsp_data(legal_p0, sel_we_p0, mem_rd);
      rsp_err_p0   = gnt_p0 && !legal_p0;
   end

   assign p0_req_ready = gnt0_p0;
   assign p1_req_ready = gnt1_p0;

   // ---- stage p1: arbitration history ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (gnt0_p0) begin
         last_grant <= 1'b0;
      end else if (gnt1_p0) begin
         last_grant <= 1'b1;
      end
   end

   // ---- stage p1: port 0 response slot ----
   // A grant refills the slot even when the old entry is drained in the same
   // cycle; data is otherwise held while the response waits to be consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0_p1   <= 1'b0;
         rdata0_p1 <= 32'd0;
         err0_p1   <= 1'b0;
      end else if (gnt0_p0) begin
         vld0_p1   <= 1'b1;
         rdata0_p1 <= rsp_rdata_p0;
         err0_p1   <= rsp_err_p0;
      end else if (p0_rsp_ready) begin
         vld0_p1   <= 1'b0;
      end
   end

   // ---- stage p1: port 1 response slot ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_p1   <= 1'b0;
         rdata1_p1 <= 32'd0;
         err1_p1   <= 1'b0;
      end else if (gnt1_p0) begin
         vld1_p1   <= 1'b1;
         rdata1_p1 <= rsp_rdata_p0;
         err1_p1   <= rsp_err_p0;
      end else if (p1_rsp_ready) begin
         vld1_p1   <= 1'b0;
      end
   end

   assign p0_rsp_valid = vld0_p1;
   assign p0_rsp_rdata = rdata0_p1;
   assign p0_rsp_err   = err0_p1;
   assign p1_rsp_valid = vld1_p1;
   assign p1_rsp_rdata = rdata1_p1;
   assign p1_rsp_err   = err1_p1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Requester-side stimulus, index = port number.
   logic [1:0]       v, we, rr;
   logic [1:0][31:0] addr, wd;

   logic p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
   logic p0_rsp_err, p1_rsp_err;
   logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
   logic mem_read, mem_write;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   logic [1:0]       rdy, rvld, rerr;
   logic [1:0][31:0] rdata;
   assign rdy   = {p1_req_ready, p0_req_ready};
   assign rvld  = {p1_rsp_valid, p0_rsp_valid};
   assign rerr  = {p1_rsp_err, p0_rsp_err};
   assign rdata = {p1_rsp_rdata, p0_rsp_rdata};

   dmem_port_arbiter #(.ADDR_LIMIT(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(v[0]), .p0_req_ready(p0_req_ready), .p0_req_we(we[0]),
      .p0_req_addr(addr[0]), .p0_req_wdata(wd[0]),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(rr[0]),
      .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
      .p1_req_valid(v[1]), .p1_req_ready(p1_req_ready), .p1_req_we(we[1]),
      .p1_req_addr(addr[1]), .p1_req_wdata(wd[1]),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(rr[1]),
      .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Physical 1 KB byte memory driven by the DUT.
   logic [7:0] pmem [0:1023];
   assign mem_rd = {pmem[{mem_addr[9:2], 2'd3}], pmem[{mem_addr[9:2], 2'd2}],
                    pmem[{mem_addr[9:2], 2'd1}], pmem[{mem_addr[9:2], 2'd0}]};
   always @(posedge clk) begin
      if (mem_write) begin
         pmem[{mem_addr[9:2], 2'd0}] <= mem_wd[7:0];
         pmem[{mem_addr[9:2], 2'd1}] <= mem_wd[15:8];
         pmem[{mem_addr[9:2], 2'd2}] <= mem_wd[23:16];
         pmem[{mem_addr[9:2], 2'd3}] <= mem_wd[31:24];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0]      ref_mem [0:255];
   logic             m_last;
   logic [1:0]       m_vld, m_err;
   logic [1:0][31:0] m_rdata;
   int               glog [$];

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= 32'd1020);
   endfunction

   // Which port the rules say wins this cycle, -1 for none.
   function automatic int pick();
      logic e0, e1;
      e0 = v[0] && (!m_vld[0] || rr[0]);
      e1 = v[1] && (!m_vld[1] || rr[1]);
      if (e0 && e1) return m_last ? 0 : 1;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int g;
      logic lg;
      if (!rst_n) begin
         m_last  = 1'b1;
         m_vld   = '0;
         m_err   = '0;
         m_rdata = '0;
      end else begin
         g = pick();
         for (int i = 0; i < 2; i++) begin
            if (i == g) begin
               lg         = legal(addr[i]);
               m_vld[i]   = 1'b1;
               m_err[i]   = !lg;
               m_rdata[i] = (lg && !we[i]) ? ref_mem[addr[i][9:2]] : 32'd0;
               if (lg && we[i]) ref_mem[addr[i][9:2]] = wd[i];
            end else if (rr[i]) begin
               m_vld[i] = 1'b0;
            end
         end
         if (g >= 0) m_last = g[0];
      end
   end

   always @(negedge clk) begin
      int g;
      logic lg;
      if (!rst_n) begin
         chk("rst_rsp_valid", 32'(rvld), 32'd0);
         chk("rst_rsp_err", 32'(rerr), 32'd0);
         chk("rst_rdata0", rdata[0], 32'd0);
         chk("rst_rdata1", rdata[1], 32'd0);
      end else begin
         g = pick();
         chk("req_ready", 32'(rdy), (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
         if (g >= 0) begin
            lg = legal(addr[g]);
            chk("mem_read", 32'(mem_read), 32'(lg && !we[g]));
            chk("mem_write", 32'(mem_write), 32'(lg && we[g]));
            if (lg) chk("mem_addr", mem_addr, addr[g]);
            if (lg && we[g]) chk("mem_wd", mem_wd, wd[g]);
         end else begin
            chk("idle_read", 32'(mem_read), 32'd0);
            chk("idle_write", 32'(mem_write), 32'd0);
            chk("idle_addr", mem_addr, 32'd0);
            chk("idle_wd", mem_wd, 32'd0);
         end
         for (int i = 0; i < 2; i++) begin
            chk("rsp_valid", 32'(rvld[i]), 32'(m_vld[i]));
            if (m_vld[i]) begin
               chk("rsp_rdata", rdata[i], m_rdata[i]);
               chk("rsp_err", 32'(rerr[i]), 32'(m_err[i]));
            end
         end
         if (rdy[0]) glog.push_back(0);
         if (rdy[1]) glog.push_back(1);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic        err;
   } ill_t;
   ill_t ill [6];
   int   n0, n1;

   initial begin
      for (int i = 0; i < 1024; i++) pmem[i] = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      rst_n = 1'b0; v = '0; we = '0; rr = 2'b11; addr = '0; wd = '0;
      step(); step();
      chk("reset_rsp_valid", 32'(rvld), 32'd0);
      rst_n = 1'b1;

      // Fairness: both ports valid, tie goes to port 0 first.
      glog.delete();
      v = 2'b11; addr[0] = 32'h100; addr[1] = 32'h200;
      repeat (16) step();
      v = '0;
      chk("fair_count", glog.size(), 32'd16);
      n0 = 0; n1 = 0;
      for (int k = 0; k < glog.size(); k++) begin
         if (k < 16) chk("fair_order", glog[k], k % 2);
         if (glog[k] == 0) n0++; else n1++;
      end
      chk("fair_p0", n0, 32'd8);
      chk("fair_p1", n1, 32'd8);

      // Port 0 write then same-address read.
      v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h010; wd[0] = 32'hDEADBEEF;
      step();
      we[0] = 1'b0;
      step();
      chk("wr_rd_valid", 32'(rvld[0]), 32'd1);
      chk("wr_rd_data", rdata[0], 32'hDEADBEEF);
      chk("wr_rd_err", 32'(rerr[0]), 32'd0);
      chk("byte_010", 32'(pmem[16]), 32'hEF);
      chk("byte_013", 32'(pmem[19]), 32'hDE);
      v = '0;
      step();

      // Back-pressure on port 0 (last winner is port 0, so port 1 goes first).
      glog.delete();
      v = 2'b11; addr[1] = 32'h200;
      step(); step();
      rr[0] = 1'b0;
      repeat (4) step();
      chk("bp_count", glog.size(), 32'd6);
      for (int k = 0; k < glog.size(); k++)
         if (k < 6) chk("bp_order", glog[k], (k == 1) ? 32'd0 : 32'd1);
      chk("bp_held_data", rdata[0], 32'hDEADBEEF);
      rr[0] = 1'b1;
      #1;
      chk("bp_release_ready", 32'(rdy), 32'd1);
      step();
      v = '0;
      step();

      // Illegal requests and the top legal word.
      ill[0] = '{1'b0, 32'h0000_0002, 32'h0, 1'b1};
      ill[1] = '{1'b0, 32'h0000_03FD, 32'h0, 1'b1};
      ill[2] = '{1'b1, 32'h0000_0400, 32'hBAD0BAD0, 1'b1};
      ill[3] = '{1'b1, 32'h0001_0010, 32'hBAD0BAD0, 1'b1};
      ill[4] = '{1'b1, 32'h0000_03FC, 32'hCAFEF00D, 1'b0};
      ill[5] = '{1'b0, 32'h0000_03FC, 32'h0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         v[0] = 1'b1; we[0] = ill[k].we; addr[0] = ill[k].a; wd[0] = ill[k].d;
         step();
         chk("ill_err", 32'(rerr[0]), 32'(ill[k].err));
         chk("ill_rdata", rdata[0], (k == 5) ? 32'hCAFEF00D : 32'd0);
      end
      v = '0;
      step();
      chk("ill_mem_000", {pmem[3], pmem[2], pmem[1], pmem[0]}, 32'd0);
      chk("ill_mem_010", {pmem[19], pmem[18], pmem[17], pmem[16]}, 32'hDEADBEEF);

      // Reset while a port 1 read response is pending.
      v[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h010; rr[1] = 1'b0;
      step();
      v[1] = 1'b0;
      chk("pre_rst_valid", 32'(rvld[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_clear", 32'(rvld[1]), 32'd0);
      step(); step();
      rst_n = 1'b1; rr = 2'b11;
      step();
      chk("post_rst_norsp", 32'(rvld), 32'd0);
      v = 2'b11; we = '0; addr[0] = 32'h010; addr[1] = 32'h010;
      #1;
      chk("post_rst_first", 32'(rdy), 32'd1);
      step();
      v = '0;
      step();

      // Back-to-back writes from port 1, then read both back.
      v[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h020; wd[1] = 32'h11111111;
      step();
      chk("b2b_w1_err", 32'(rerr[1]), 32'd0);
      addr[1] = 32'h024; wd[1] = 32'h22222222;
      step();
      chk("b2b_w2_valid", 32'(rvld[1]), 32'd1);
      chk("b2b_w2_err", 32'(rerr[1]), 32'd0);
      we[1] = 1'b0; addr[1] = 32'h020;
      step();
      chk("b2b_rd1", rdata[1], 32'h11111111);
      addr[1] = 32'h024;
      step();
      chk("b2b_rd2", rdata[1], 32'h22222222);
      v = '0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
